alu_share_arbiter: RTL and testbench

- Time-shares one arimetric_unit between two requesters, e.g. the PC-increment path and the execute stage.
- Uses a round-robin arbiter with a req/ack handshake.
- Latches the winner's operands and drives the shared unit for one cycle.
- Registers the result and returns it with a per-requester valid pulse.
- Sits between the requesters and a single arimetric_unit instance. It also keeps saturating per-requester grant counters for performance monitoring.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one external arithmetic unit between two requesters using a round-robin
// req/ack arbiter, returning registered results with per-requester valid pulses.
module alu_share_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [2:0]       op0,
    input  logic [31:0]      a0,
    input  logic [31:0]      b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [2:0]       op1,
    input  logic [31:0]      a1,
    input  logic [31:0]      b1,
    output logic             ack1,
    output logic [2:0]       alu_opcode,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    output logic [31:0]      rsp_data,
    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   win_valid;
    logic   winner;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // Arbitration is only open in IDLE and in the RESP window; on a tie the
    // requester that did not win last time gets the unit.
    always_comb begin
        win_valid = 1'b0;
        winner    = 1'b0;
        if ((state == IDLE) || (state == RESP)) begin
            if (req0 && req1) begin
                win_valid = 1'b1;
                winner    = ~last_grant;
            end else if (req0) begin
                win_valid = 1'b1;
                winner    = 1'b0;
            end else if (req1) begin
                win_valid = 1'b1;
                winner    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_data   <= 32'd0;
            alu_opcode <= 3'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            busy       <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (win_valid) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        last_grant <= winner;
                        owner      <= winner;
                        if (winner) begin
                            alu_opcode <= op1;
                            alu_a      <= a1;
                            alu_b      <= b1;
                            ack1       <= 1'b1;
                            grant_cnt1 <= sat_inc(grant_cnt1);
                        end else begin
                            alu_opcode <= op0;
                            alu_a      <= a0;
                            alu_b      <= b0;
                            ack0       <= 1'b1;
                            grant_cnt0 <= sat_inc(grant_cnt0);
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // The shared unit is combinational; capture its result now.
                    rsp_data   <= alu_out;
                    rsp_valid0 <= ~owner;
                    rsp_valid1 <= owner;
                    state      <= RESP;
                    busy       <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural shared unit and a
// response scoreboard; a second instance with CNT_W=2 covers counter saturation.
module tb_alu_share_arbiter;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    logic        ack0, ack1;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [31:0] rsp_data;
    logic        rsp_valid0, rsp_valid1, busy;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic        s_req0, s_req1;
    logic        s_ack0, s_ack1;
    logic [2:0]  s_alu_opcode;
    logic [31:0] s_alu_a, s_alu_b, s_alu_out, s_rsp_data;
    logic        s_rsp_valid0, s_rsp_valid1, s_busy;
    logic [1:0]  s_cnt0, s_cnt1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        case (op)
            3'b010:  return a + b;
            3'b110:  return d;
            3'b111:  return {32{d[31]}};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out   = alu_model(alu_opcode, alu_a, alu_b);
    assign s_alu_out = alu_model(s_alu_opcode, s_alu_a, s_alu_b);

    alu_share_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_data(rsp_data), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_share_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req0(s_req0), .op0(3'b010), .a0(32'd0), .b0(32'd0), .ack0(s_ack0),
        .req1(s_req1), .op1(3'b010), .a1(32'd9), .b1(32'd1), .ack1(s_ack1),
        .alu_opcode(s_alu_opcode), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_out(s_alu_out),
        .rsp_data(s_rsp_data), .rsp_valid0(s_rsp_valid0), .rsp_valid1(s_rsp_valid1),
        .busy(s_busy), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Single transaction with bounded waits for ack and for the response.
    task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        bit got;
        sb.push_back('{owner: id, data: exp});
        if (id) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (id ? ack1 : ack0) got = 1'b1;
        end
        check("op_ack_seen", got, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        got  = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (id ? rsp_valid1 : rsp_valid0) got = 1'b1;
        end
        check("op_rsp_seen", got, 1);
        tick();
    endtask

    // Scoreboard monitor: pops one expectation per response, checks exclusivity.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("ack_exclusive", ack0 & ack1, 0);
            check("valid_exclusive", rsp_valid0 & rsp_valid1, 0);
            if (rsp_valid0 || rsp_valid1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_rsp_owner", rsp_valid1, e.owner);
                    check("sb_rsp_data", rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_ack;
        int nacks;
        int base0, base1, d0, d1;
        int nsat;
        logic exp_next;
        logic [1:0] exp_cnt;

        reset = 1'b1;
        req0 = 1'b0; op0 = 3'd0; a0 = 32'd0; b0 = 32'd0;
        req1 = 1'b0; op1 = 3'd0; a1 = 32'd0; b1 = 32'd0;
        s_req0 = 1'b0; s_req1 = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ctrl", {ack0, ack1, rsp_valid0, rsp_valid1, busy}, 0);
        check("rst_alu", {alu_opcode, alu_a, alu_b} == 0, 1);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_cnts", {grant_cnt0, grant_cnt1}, 0);
        reset = 1'b0;
        tick();

        // Single add 5+3 from requester 0
        sb.push_back('{owner: 1'b0, data: 32'd8});
        req0 = 1'b1; op0 = 3'b010; a0 = 32'd5; b0 = 32'd3;
        tick();
        check("add_ack0", ack0, 1);
        check("add_ack1", ack1, 0);
        check("add_busy", busy, 1);
        check("add_alu_op", alu_opcode, 3'b010);
        check("add_alu_ab", {alu_a, alu_b}, {32'd5, 32'd3});
        req0 = 1'b0;
        tick();
        check("add_valid0", rsp_valid0, 1);
        check("add_valid1", rsp_valid1, 0);
        check("add_data", rsp_data, 32'd8);
        check("add_cnt0", grant_cnt0, 1);
        tick();
        check("add_idle", busy, 0);
        check("add_data_hold", rsp_data, 32'd8);
        check("add_alu_hold", alu_a, 32'd5);

        // Tie straight after reset: requester 0 first
        do_reset();
        sb.push_back('{owner: 1'b0, data: 32'd6});
        sb.push_back('{owner: 1'b1, data: 32'd2});
        req0 = 1'b1; op0 = 3'b110; a0 = 32'd10; b0 = 32'd4;
        req1 = 1'b1; op1 = 3'b010; a1 = 32'd1;  b1 = 32'd1;
        tick();
        check("tie_ack0", ack0, 1);
        check("tie_ack1_first", ack1, 0);
        req0 = 1'b0;
        tick();
        check("tie_valid0", rsp_valid0, 1);
        check("tie_data0", rsp_data, 32'd6);
        tick();
        check("tie_ack1", ack1, 1);
        check("tie_valid0_clear", rsp_valid0, 0);
        req1 = 1'b0;
        tick();
        check("tie_valid1", rsp_valid1, 1);
        check("tie_data1", rsp_data, 32'd2);
        check("tie_cnts", {grant_cnt0, grant_cnt1}, {16'd1, 16'd1});
        tick();
        check("tie_idle", busy, 0);

        // SLT on requester 1
        run_op(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_op(1'b1, 3'b111, 32'd7, 32'd3, 32'd0);
        run_op(1'b0, 3'b110, 32'd3, 32'd7, 32'hFFFF_FFFC);

        // Continuous contention for 20 cycles
        do_reset();
        base0 = grant_cnt0;
        base1 = grant_cnt1;
        req0 = 1'b1; op0 = 3'b010; a0 = 32'd100; b0 = 32'd1;
        req1 = 1'b1; op1 = 3'b110; a1 = 32'd50;  b1 = 32'd8;
        exp_next = 1'b0;
        prev_ack = -1;
        nacks = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ack0 || ack1) begin
                check("cont_alternate", ack1, exp_next);
                if (prev_ack >= 0) check("cont_spacing", c - prev_ack, 2);
                sb.push_back('{owner: ack1, data: ack1 ? 32'd42 : 32'd101});
                exp_next = ~exp_next;
                prev_ack = c;
                nacks++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("cont_ack_count", nacks, 10);
        tick();
        tick();
        tick();
        check("cont_idle", busy, 0);
        d0 = grant_cnt0 - base0;
        d1 = grant_cnt1 - base1;
        check("cont_balance", (d0 - d1 <= 1) && (d1 - d0 <= 1), 1);
        check("cont_total", d0 + d1, 10);
        check("sb_drained", sb.size(), 0);

        // Reset during ISSUE drops the transaction
        req0 = 1'b1; op0 = 3'b010; a0 = 32'd2; b0 = 32'd2;
        tick();
        check("midrst_ack0", ack0, 1);
        reset = 1'b1;
        req0 = 1'b0;
        tick();
        check("midrst_ctrl", {ack0, ack1, rsp_valid0, rsp_valid1, busy}, 0);
        check("midrst_data", {rsp_data, alu_a, alu_b}, 0);
        check("midrst_op", alu_opcode, 0);
        check("midrst_cnts", {grant_cnt0, grant_cnt1}, 0);
        reset = 1'b0;
        tick();
        check("midrst_no_valid", rsp_valid0 | rsp_valid1, 0);
        tick();
        check("midrst_no_valid2", rsp_valid0 | rsp_valid1, 0);

        // Saturation on the CNT_W=2 instance: 1,2,3,3,3
        s_req1 = 1'b1;
        nsat = 0;
        for (int c = 0; c < 30 && nsat < 5; c++) begin
            tick();
            if (s_ack1) begin
                nsat++;
                exp_cnt = (nsat > 3) ? 2'd3 : 2'(nsat);
                check("sat_cnt1", s_cnt1, exp_cnt);
            end
        end
        s_req1 = 1'b0;
        check("sat_grants", nsat, 5);
        check("sat_cnt0", s_cnt0, 0);
        tick();
        tick();
        tick();
        check("sat_idle", s_busy, 0);
        check("sat_data", s_rsp_data, 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
